// File: rtl/cdc_mailbox_rx.sv
// Receive side of a toggle-handshake mailbox: settles the synchronized request,
// captures the held word into a small FWFT FIFO and returns an ack toggle.
module cdc_mailbox_rx #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_sync,
  input  logic [WIDTH-1:0]           data_sync,
  output logic                       ack,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       busy
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic               ack_d;
  logic               push;
  logic               pop;
  logic               space;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count_d;
  logic [WIDTH-1:0]   mem [DEPTH];

  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign pop   = out_valid && out_ready;
  assign space = (fifo_count < CNT_W'(DEPTH)) || pop;

  // Handshake state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      settle_q <= '0;
      ack      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      ack      <= ack_d;
      busy     <= (state_d != IDLE);
    end
  end

  // Next-state: detect pending request, wait out the settle interval, capture
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    ack_d    = ack;
    push     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_sync != ack) begin
          state_d  = SETTLE;
          settle_d = SET_W'(SETTLE_CYCLES - 1);
        end
      end
      SETTLE: begin
        if (settle_q == '0) begin
          state_d = CAPTURE;
        end else begin
          settle_d = settle_q - SET_W'(1);
        end
      end
      CAPTURE: begin
        if (space) begin
          push    = 1'b1;
          ack_d   = ~ack;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Occupancy update
  always_comb begin
    count_d = fifo_count;
    if (push && !pop) begin
      count_d = fifo_count + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = fifo_count - CNT_W'(1);
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      out_valid  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_count <= count_d;
      out_valid  <= (count_d != '0);
    end
  end

  // Storage is intentionally left uninitialized across reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_sync;
  end

  assign out_data = mem[rd_ptr];

endmodule

// File: tb/tb_cdc_mailbox_rx.sv
// Self-checking bench for cdc_mailbox_rx: vector table, directed corner
// sequences on two parameterizations, and a randomized run against a queue model.
module tb_cdc_mailbox_rx;

  localparam int S1 = 2;
  localparam int D1 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default instance
  logic       reset, req_sync, out_ready, ack, out_valid, busy;
  logic [7:0] data_sync, out_data;
  logic [2:0] fifo_count;

  // SETTLE_CYCLES=1, DEPTH=2, WIDTH=1 instance
  logic       reset2, req2, ready2, ack2, valid2, busy2;
  logic [0:0] data2, odata2;
  logic [1:0] count2;

  int total = 0;
  int bad   = 0;

  cdc_mailbox_rx #(.WIDTH(8), .DEPTH(D1), .SETTLE_CYCLES(S1)) dut (
    .clk(clk), .reset(reset), .req_sync(req_sync), .data_sync(data_sync),
    .ack(ack), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fifo_count(fifo_count), .busy(busy)
  );

  cdc_mailbox_rx #(.WIDTH(1), .DEPTH(2), .SETTLE_CYCLES(1)) dut2 (
    .clk(clk), .reset(reset2), .req_sync(req2), .data_sync(data2),
    .ack(ack2), .out_data(odata2), .out_valid(valid2), .out_ready(ready2),
    .fifo_count(count2), .busy(busy2)
  );

  typedef struct {
    logic       rst;
    logic       req;
    logic [7:0] data;
    logic       e_ack;
    logic [2:0] e_cnt;
    logic       e_busy;
    logic       chk_d;
    logic [7:0] e_data;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(logic rst, logic req, logic [7:0] d, logic ea,
                              logic [2:0] ec, logic eb, logic cd, logic [7:0] ed);
    vec_t v;
    v.rst = rst; v.req = req; v.data = d; v.e_ack = ea;
    v.e_cnt = ec; v.e_busy = eb; v.chk_d = cd; v.e_data = ed;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send1(input logic [7:0] d, input int exp_lat, input string nm);
    int n;
    n = 0;
    req_sync  = ~req_sync;
    data_sync = d;
    while (ack != req_sync && n < 40) begin
      step();
      n++;
    end
    chk({nm, "_lat"}, n, exp_lat);
  endtask

  task automatic send2(input logic d, input string nm);
    int n;
    n = 0;
    req2  = ~req2;
    data2 = d;
    while (ack2 != req2 && n < 40) begin
      step();
      n++;
    end
    chk({nm, "_lat"}, n, 3);
  endtask

  // random-test model state
  logic [7:0] q[$];
  logic [7:0] got_q[$];
  logic [7:0] words[8];
  logic [7:0] exp_d[4];
  int         pct_tab[5];
  logic       m_ack, m_busy, m_pop, m_push;
  int         m_el;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int sent, cyc, last_flip, nflip, max_cnt;
    logic prev_ack;

    reset = 1'b1; req_sync = 1'b0; data_sync = 8'hF1; out_ready = 1'b0;
    reset2 = 1'b1; req2 = 1'b0; data2 = 1'b0; ready2 = 1'b0;

    // ---------------- vector table: first capture, second word, reset in CAPTURE
    tbl[0]  = mk(1, 0, 8'hF1, 0, 0, 0, 0, 8'h00);
    tbl[1]  = mk(0, 1, 8'hF1, 0, 0, 1, 0, 8'h00);
    tbl[2]  = mk(0, 1, 8'hF1, 0, 0, 1, 0, 8'h00);
    tbl[3]  = mk(0, 1, 8'hF1, 0, 0, 1, 0, 8'h00);
    tbl[4]  = mk(0, 1, 8'hF1, 1, 1, 0, 1, 8'hF1);
    tbl[5]  = mk(0, 1, 8'hF1, 1, 1, 0, 1, 8'hF1);
    tbl[6]  = mk(0, 0, 8'h5A, 1, 1, 1, 1, 8'hF1);
    tbl[7]  = mk(0, 0, 8'h5A, 1, 1, 1, 1, 8'hF1);
    tbl[8]  = mk(0, 0, 8'h5A, 1, 1, 1, 1, 8'hF1);
    tbl[9]  = mk(0, 0, 8'h5A, 0, 2, 0, 1, 8'hF1);
    tbl[10] = mk(0, 1, 8'h77, 0, 2, 1, 1, 8'hF1);
    tbl[11] = mk(0, 1, 8'h77, 0, 2, 1, 1, 8'hF1);
    tbl[12] = mk(0, 1, 8'h77, 0, 2, 1, 1, 8'hF1);
    tbl[13] = mk(1, 1, 8'h77, 0, 0, 0, 0, 8'h00);
    tbl[14] = mk(0, 0, 8'h77, 0, 0, 0, 0, 8'h00);

    for (int i = 0; i < 15; i++) begin
      reset     = tbl[i].rst;
      req_sync  = tbl[i].req;
      data_sync = tbl[i].data;
      step();
      chk($sformatf("v%0d_ack", i),   ack,        tbl[i].e_ack);
      chk($sformatf("v%0d_cnt", i),   fifo_count, tbl[i].e_cnt);
      chk($sformatf("v%0d_valid", i), out_valid,  tbl[i].e_cnt != 0);
      chk($sformatf("v%0d_busy", i),  busy,       tbl[i].e_busy);
      if (tbl[i].chk_d) chk($sformatf("v%0d_data", i), out_data, tbl[i].e_data);
    end

    // ---------------- full FIFO stall, then pop and push on the same edge
    reset = 1'b1; req_sync = 1'b0; step(); reset = 1'b0;
    send1(8'h11, 4, "w1");
    send1(8'h22, 4, "w2");
    send1(8'h33, 4, "w3");
    send1(8'h44, 4, "w4");
    chk("full_cnt", fifo_count, 4);
    req_sync = ~req_sync; data_sync = 8'h55;
    repeat (6) step();
    chk("stall_ack",  ack,        0);
    chk("stall_busy", busy,       1);
    chk("stall_cnt",  fifo_count, 4);
    chk("stall_head", out_data,   8'h11);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    chk("pp_ack",  ack,        1);
    chk("pp_cnt",  fifo_count, 4);
    chk("pp_busy", busy,       0);
    exp_d[0] = 8'h22; exp_d[1] = 8'h33; exp_d[2] = 8'h44; exp_d[3] = 8'h55;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d", i), out_data, exp_d[i]);
      out_ready = 1'b1; step(); out_ready = 1'b0;
    end
    chk("drain_cnt",   fifo_count, 0);
    chk("drain_valid", out_valid,  0);

    // ---------------- bus changes during SETTLE
    req_sync = ~req_sync; data_sync = 8'hAA;
    step();
    data_sync = 8'hBB;
    step(); step();
    chk("settle_nopush", fifo_count, 0);
    step();
    chk("settle_cnt",  fifo_count, 1);
    chk("settle_data", out_data,   8'hBB);
    out_ready = 1'b1; step();

    // ---------------- streaming with out_ready held high
    for (int i = 0; i < 8; i++) words[i] = 8'($urandom);
    got_q.delete();
    sent = 0; cyc = 0; last_flip = 0; nflip = 0; max_cnt = 0; prev_ack = ack;
    while (got_q.size() < 8 && cyc < 200) begin
      if (out_valid && out_ready) got_q.push_back(out_data);
      if (ack == req_sync && sent < 8) begin
        req_sync = ~req_sync; data_sync = words[sent]; sent++;
      end
      step();
      cyc++;
      if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
      if (ack != prev_ack) begin
        if (nflip > 0) chk($sformatf("stream_gap%0d", nflip), cyc - last_flip, 4);
        last_flip = cyc; nflip++; prev_ack = ack;
      end
    end
    step();
    chk("stream_words", got_q.size(), 8);
    chk("stream_maxcnt", max_cnt, 1);
    for (int i = 0; i < 8 && i < got_q.size(); i++)
      chk($sformatf("stream_ord%0d", i), got_q[i], words[i]);
    chk("stream_empty", fifo_count, 0);
    out_ready = 1'b0;

    // ---------------- SETTLE_CYCLES=1, DEPTH=2, WIDTH=1
    reset2 = 1'b0;
    chk("d2_rst_cnt", count2, 0);
    send2(1'b1, "d2w1");
    send2(1'b0, "d2w2");
    chk("d2_full", count2, 2);
    req2 = ~req2; data2 = 1'b1;
    repeat (5) step();
    chk("d2_stall_ack",  ack2,   0);
    chk("d2_stall_busy", busy2,  1);
    chk("d2_stall_head", odata2, 1);
    ready2 = 1'b1; step(); ready2 = 1'b0;
    chk("d2_pp_ack",  ack2,   1);
    chk("d2_pp_cnt",  count2, 2);
    chk("d2_pp_busy", busy2,  0);
    chk("d2_head0",   odata2, 0);
    ready2 = 1'b1; step(); ready2 = 1'b0;
    chk("d2_head1",   odata2, 1);
    ready2 = 1'b1; step(); ready2 = 1'b0;
    chk("d2_empty",   valid2, 0);

    // ---------------- randomized run against a queue model
    reset = 1'b1; req_sync = 1'b0; out_ready = 1'b0; step(); reset = 1'b0;
    q.delete(); m_ack = 1'b0; m_busy = 1'b0; m_el = 0;
    pct_tab[0] = 80; pct_tab[1] = 10; pct_tab[2] = 50; pct_tab[3] = 0; pct_tab[4] = 100;
    for (int c = 0; c < 2000; c++) begin
      if (req_sync == m_ack && $urandom_range(0, 1) == 0) begin
        req_sync  = ~req_sync;
        data_sync = 8'($urandom);
      end
      out_ready = ($urandom_range(0, 99) < pct_tab[(c / 200) % 5]);
      // a word is captured S+1 edges after detection, at the first edge with room
      m_pop  = (q.size() != 0) && out_ready;
      m_push = 1'b0;
      if (m_busy) begin
        m_el++;
        if (m_el >= S1 + 1 && (q.size() < D1 || m_pop)) m_push = 1'b1;
      end
      step();
      if (m_pop) void'(q.pop_front());
      if (m_push) begin
        q.push_back(data_sync);
        m_ack  = ~m_ack;
        m_busy = 1'b0;
      end else if (!m_busy && req_sync != m_ack) begin
        m_busy = 1'b1;
        m_el   = 0;
      end
      chk($sformatf("r%0d_ack", c),   ack,        m_ack);
      chk($sformatf("r%0d_cnt", c),   fifo_count, q.size());
      chk($sformatf("r%0d_valid", c), out_valid,  q.size() != 0);
      chk($sformatf("r%0d_busy", c),  busy,       m_busy);
      if (q.size() != 0) chk($sformatf("r%0d_data", c), out_data, q[0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
